pad_block_assembler: RTL and testbench

PAD_BLOCK_ASSEMBLER -- requirements
Module: pad_block_assembler

---
 rtl/pad_block_assembler.sv | 141 ++++++++++++++
 tb/tb_pad_block_assembler.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pad_block_assembler.sv
// Packs 64-bit message words into 1088-bit rate blocks and appends the pad10*1 padding.
// Define PAD_SHA3_DOMAIN_EN for the SHA3 domain byte 0x06; otherwise the Keccak byte 0x01 is used.
module pad_block_assembler (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [63:0]   in_word,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic [3:0]    in_bytes,
  output logic          in_ready,
  output logic [1087:0] out_block,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready
);

`ifdef PAD_SHA3_DOMAIN_EN
  localparam logic [7:0] DOMAIN_BYTE = 8'h06;
`else
  localparam logic [7:0] DOMAIN_BYTE = 8'h01;
`endif

  localparam int         NUM_LANES  = 17;
  localparam logic [4:0] LAST_LANE  = 5'd16;
  localparam logic [7:0] RATE_BYTES = 8'd136;

  typedef enum logic [1:0] {FILL, PAD, OUT} state_t;

  state_t      state, state_nxt;
  logic [4:0]  lane_cnt, lane_cnt_nxt;
  logic        pad_pend, pad_pend_nxt;
  logic        last_q, last_nxt;
  logic        armed;
  logic [63:0] lanes     [NUM_LANES];
  logic [63:0] lanes_nxt [NUM_LANES];
  logic [3:0]  eff_bytes;
  logic [7:0]  pad_pos;
  logic [63:0] masked_word;
  logic        word_xfer;
  logic        blk_xfer;

  // armed keeps in_ready low while reset is held and raises it on the first edge after release
  assign in_ready  = armed && (state == FILL);
  assign out_valid = (state == OUT);
  assign out_last  = last_q;
  assign word_xfer = in_valid && in_ready;
  assign blk_xfer  = out_valid && out_ready;
  assign eff_bytes = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
  assign pad_pos   = {lane_cnt, 3'b000} + {4'b0000, eff_bytes};

  always_comb begin
    masked_word = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < eff_bytes) masked_word[8*k +: 8] = in_word[8*k +: 8];
    end
  end

  always_comb begin
    out_block = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      out_block[1087-64*n -: 64] = lanes[n];
    end
  end

  always_comb begin
    state_nxt    = state;
    lane_cnt_nxt = lane_cnt;
    pad_pend_nxt = pad_pend;
    last_nxt     = last_q;
    lanes_nxt    = lanes;
    unique case (state)
      FILL: begin
        if (word_xfer) begin
          for (int n = 0; n < NUM_LANES; n++) begin
            if (5'(n) == lane_cnt) lanes_nxt[n] = in_last ? masked_word : in_word;
          end
          if (!in_last) begin
            if (lane_cnt == LAST_LANE) begin
              state_nxt = OUT;
              last_nxt  = 1'b0;
            end else begin
              lane_cnt_nxt = lane_cnt + 5'd1;
            end
          end else if (pad_pos < RATE_BYTES) begin
            // Domain byte lands right after the last message byte; may share byte 135 with 0x80
            for (int n = 0; n < NUM_LANES; n++) begin
              for (int k = 0; k < 8; k++) begin
                if (8'(8*n + k) == pad_pos)
                  lanes_nxt[n][8*k +: 8] = lanes_nxt[n][8*k +: 8] | DOMAIN_BYTE;
              end
            end
            lanes_nxt[NUM_LANES-1][63:56] = lanes_nxt[NUM_LANES-1][63:56] | 8'h80;
            last_nxt  = 1'b1;
            state_nxt = OUT;
          end else begin
            // Block is exactly full: padding needs a whole extra block
            last_nxt     = 1'b0;
            pad_pend_nxt = 1'b1;
            state_nxt    = OUT;
          end
        end
      end
      PAD: begin
        for (int n = 0; n < NUM_LANES; n++) lanes_nxt[n] = '0;
        lanes_nxt[0][7:0]             = DOMAIN_BYTE;
        lanes_nxt[NUM_LANES-1][63:56] = 8'h80;
        pad_pend_nxt = 1'b0;
        last_nxt     = 1'b1;
        state_nxt    = OUT;
      end
      OUT: begin
        if (blk_xfer) begin
          for (int n = 0; n < NUM_LANES; n++) lanes_nxt[n] = '0;
          lane_cnt_nxt = 5'd0;
          last_nxt     = 1'b0;
          state_nxt    = pad_pend ? PAD : FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      lane_cnt <= 5'd0;
      pad_pend <= 1'b0;
      last_q   <= 1'b0;
      armed    <= 1'b0;
      for (int n = 0; n < NUM_LANES; n++) lanes[n] <= '0;
    end else begin
      state    <= state_nxt;
      lane_cnt <= lane_cnt_nxt;
      pad_pend <= pad_pend_nxt;
      last_q   <= last_nxt;
      armed    <= 1'b1;
      for (int n = 0; n < NUM_LANES; n++) lanes[n] <= lanes_nxt[n];
    end
  end

endmodule

// File: tb/tb_pad_block_assembler.sv
// Directed self-checking bench for pad_block_assembler; expected blocks are built from constants.
module tb_pad_block_assembler;

`ifdef PAD_SHA3_DOMAIN_EN
  localparam logic [7:0] D = 8'h06;
`else
  localparam logic [7:0] D = 8'h01;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [63:0]   in_word = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic [3:0]    in_bytes = '0;
  logic          in_ready;
  logic [1087:0] out_block;
  logic          out_valid;
  logic          out_last;
  logic          out_ready = 1'b0;

  int compared = 0;
  int mismatched = 0;

  logic [1087:0] blk, exp_blk;
  logic          blk_last;
  logic [63:0]   words [17];

  pad_block_assembler dut (
    .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid),
    .in_last(in_last), .in_bytes(in_bytes), .in_ready(in_ready),
    .out_block(out_block), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkBlock(input string tag, input logic [1087:0] observed, input logic [1087:0] expected);
    for (int n = 0; n < 17; n++)
      checkOutput($sformatf("%s_lane%0d", tag, n), observed[1087-64*n -: 64], expected[1087-64*n -: 64]);
  endtask

  function automatic logic [1087:0] setLane(input logic [1087:0] b, input int n, input logic [63:0] v);
    b[1087-64*n -: 64] = v;
    return b;
  endfunction

  // One word transfer, waiting a bounded time for in_ready
  task automatic applyStimulus(input logic [63:0] w, input logic last, input logic [3:0] nbytes);
    int cyc = 0;
    in_word = w; in_last = last; in_bytes = nbytes; in_valid = 1'b1;
    while (!in_ready && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", {63'b0, in_ready}, 64'd1);
    else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic collectBlock(output logic [1087:0] b, output logic lst);
    int cyc = 0;
    out_ready = 1'b1;
    while (!out_valid && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    if (!out_valid) begin
      checkOutput("out_valid_timeout", {63'b0, out_valid}, 64'd1);
      b = '0; lst = 1'b0;
    end else begin
      checkOutput("in_ready_during_out", {63'b0, in_ready}, 64'd0);
      b = out_block; lst = out_last;
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_out_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("rst_out_last", {63'b0, out_last}, 64'd0);
    checkOutput("rst_in_ready", {63'b0, in_ready}, 64'd0);
    checkBlock("rst_block", out_block, '0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 checkOutput("in_ready_before_edge", {63'b0, in_ready}, 64'd0);
    @(posedge clk); #1;
    checkOutput("in_ready_after_reset", {63'b0, in_ready}, 64'd1);

    // Empty message
    applyStimulus(64'h0, 1'b1, 4'd0);
    checkOutput("empty_latency", {63'b0, out_valid}, 64'd1);
    collectBlock(blk, blk_last);
    exp_blk = setLane('0, 0, {56'h0, D});
    exp_blk = setLane(exp_blk, 16, 64'h8000000000000000);
    checkBlock("empty", blk, exp_blk);
    checkOutput("empty_last", {63'b0, blk_last}, 64'd1);

    // "abc"
    applyStimulus(64'h0000000000636261, 1'b1, 4'd3);
    collectBlock(blk, blk_last);
    exp_blk = setLane('0, 0, {32'h0, D, 24'h636261});
    exp_blk = setLane(exp_blk, 16, 64'h8000000000000000);
    checkBlock("abc", blk, exp_blk);
    checkOutput("abc_last", {63'b0, blk_last}, 64'd1);

    // Garbage above in_bytes is masked
    applyStimulus(64'hFFFFFFFFFF636261, 1'b1, 4'd3);
    collectBlock(blk, blk_last);
    checkBlock("mask", blk, exp_blk);

    // in_bytes > 8 behaves as 8: domain byte goes to lane 1 byte 0
    applyStimulus(64'hAABBCCDDEEFF1122, 1'b1, 4'd12);
    collectBlock(blk, blk_last);
    exp_blk = setLane('0, 0, 64'hAABBCCDDEEFF1122);
    exp_blk = setLane(exp_blk, 1, {56'h0, D});
    exp_blk = setLane(exp_blk, 16, 64'h8000000000000000);
    checkBlock("clamp", blk, exp_blk);
    checkOutput("clamp_last", {63'b0, blk_last}, 64'd1);

    // 17 full words, last on word 17: data block then an all-pad block
    for (int i = 0; i < 17; i++) words[i] = {32'hA5A50000 | 32'(i), 32'(i * 3 + 1)};
    for (int i = 0; i < 17; i++) applyStimulus(words[i], (i == 16), 4'd8);
    collectBlock(blk, blk_last);
    exp_blk = '0;
    for (int i = 0; i < 17; i++) exp_blk = setLane(exp_blk, i, words[i]);
    checkBlock("full17_b1", blk, exp_blk);
    checkOutput("full17_b1_last", {63'b0, blk_last}, 64'd0);
    checkOutput("pad_cycle_in_ready", {63'b0, in_ready}, 64'd0);
    collectBlock(blk, blk_last);
    exp_blk = setLane('0, 0, {56'h0, D});
    exp_blk = setLane(exp_blk, 16, 64'h8000000000000000);
    checkBlock("full17_b2", blk, exp_blk);
    checkOutput("full17_b2_last", {63'b0, blk_last}, 64'd1);

    // 16 full + last with 7 bytes: domain and 0x80 share byte 135
    for (int i = 0; i < 16; i++) applyStimulus(words[i], 1'b0, 4'd0);
    applyStimulus(64'hFF11223344556677, 1'b1, 4'd7);
    collectBlock(blk, blk_last);
    exp_blk = '0;
    for (int i = 0; i < 16; i++) exp_blk = setLane(exp_blk, i, words[i]);
    exp_blk = setLane(exp_blk, 16, {D | 8'h80, 56'h11223344556677});
    checkBlock("p135", blk, exp_blk);
    checkOutput("p135_last", {63'b0, blk_last}, 64'd1);

    // Backpressure: block held stable for 10 cycles, offered words not taken
    applyStimulus(64'h0000000000636261, 1'b1, 4'd3);
    in_word = 64'hDEADBEEFDEADBEEF; in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("hold_valid_%0d", i), {63'b0, out_valid}, 64'd1);
      checkOutput($sformatf("hold_in_ready_%0d", i), {63'b0, in_ready}, 64'd0);
      checkOutput($sformatf("hold_lane0_%0d", i), out_block[1087 -: 64], {32'h0, D, 24'h636261});
      checkOutput($sformatf("hold_last_%0d", i), {63'b0, out_last}, 64'd1);
    end
    in_valid = 1'b0;
    collectBlock(blk, blk_last);
    exp_blk = setLane('0, 0, {32'h0, D, 24'h636261});
    exp_blk = setLane(exp_blk, 16, 64'h8000000000000000);
    checkBlock("hold", blk, exp_blk);
    applyStimulus(64'h0, 1'b1, 4'd0);
    collectBlock(blk, blk_last);
    exp_blk = setLane('0, 0, {56'h0, D});
    exp_blk = setLane(exp_blk, 16, 64'h8000000000000000);
    checkBlock("after_hold", blk, exp_blk);

    // Reset after 5 words discards the partial block
    for (int i = 0; i < 5; i++) applyStimulus(words[i], 1'b0, 4'd0);
    #2 rst_n = 1'b0;
    #1;
    checkBlock("midmsg_rst", out_block, '0);
    checkOutput("midmsg_rst_in_ready", {63'b0, in_ready}, 64'd0);
    checkOutput("midmsg_rst_out_valid", {63'b0, out_valid}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(64'h0000000000636261, 1'b1, 4'd3);
    collectBlock(blk, blk_last);
    exp_blk = setLane('0, 0, {32'h0, D, 24'h636261});
    exp_blk = setLane(exp_blk, 16, 64'h8000000000000000);
    checkBlock("post_rst", blk, exp_blk);
    checkOutput("post_rst_last", {63'b0, blk_last}, 64'd1);

    // Reset while a block waits in OUT drops it
    applyStimulus(64'h1122334455667788, 1'b1, 4'd8);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midout_rst_valid", {63'b0, out_valid}, 64'd0);
    checkOutput("midout_rst_last", {63'b0, out_last}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(64'h0, 1'b1, 4'd0);
    collectBlock(blk, blk_last);
    exp_blk = setLane('0, 0, {56'h0, D});
    exp_blk = setLane(exp_blk, 16, 64'h8000000000000000);
    checkBlock("post_out_rst", blk, exp_blk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
